vga_overlay_out: RTL and testbench

- Parametrised successor to the current VGA scan-out block: timing generator, pixel-fetch request issue, latency-matched sync/blank pipeline, and an N-channel crosshair overlay mux.
- Sits between the frame-buffer read path and the VGA DAC pins.
- Generalises the fixed 640x480 timing, fixed 2-cycle fetch delay and fixed 4 crosshairs to parameters.
- Adds per-channel colour, per-channel enable, crosshair thickness, sync polarity and a frame-start pulse.

---
 rtl/vga_pkg.sv | 69 ++++++
 rtl/vga_timing_gen.sv | 58 +++++
 rtl/vga_overlay_out.sv | 174 +++++++++++++++++
 tb/tb_vga_overlay_out.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: timing defaults, derived sync windows, colour types and the
// small helpers shared by the vga_overlay_out scan-out slice.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF
                                 + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF
                                 + V_SYNC_DEF + V_BP_DEF;
   localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
   localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
   localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

   typedef logic [23:0] rgb_t;

   // per-pixel control bundle carried down the latency line
   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
      logic first;
   } beat_t;

   localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
   localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
   localparam rgb_t BAR_CYAN    = 24'h00FFFF;
   localparam rgb_t BAR_GREEN   = 24'h00FF00;
   localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
   localparam rgb_t BAR_RED     = 24'hFF0000;
   localparam rgb_t BAR_BLUE    = 24'h0000FF;
   localparam rgb_t BAR_BLACK   = 24'h000000;

   function automatic rgb_t bar_color(input logic [2:0] bar);
      rgb_t c;
      c = BAR_BLACK;
      unique case (bar)
         3'd0: c = BAR_WHITE;
         3'd1: c = BAR_YELLOW;
         3'd2: c = BAR_CYAN;
         3'd3: c = BAR_GREEN;
         3'd4: c = BAR_MAGENTA;
         3'd5: c = BAR_RED;
         3'd6: c = BAR_BLUE;
         3'd7: c = BAR_BLACK;
      endcase
      return c;
   endfunction

   // lo <= pos < lo+thick, widened so lo near 1023 never wraps
   function automatic logic in_band(input logic [9:0]  pos,
                                    input logic [9:0]  lo,
                                    input logic [10:0] thick);
      logic [10:0] p;
      logic [10:0] l;
      p = {1'b0, pos};
      l = {1'b0, lo};
      return (p >= l) && (p < l + thick);
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters and the stage-0 decode of
// visible region, raw (active-high) syncs and the frame origin.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic       clock,
   input  logic       reset,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       active,
   output logic       hsync,
   output logic       vsync,
   output logic       first
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   // raster counters; the line count advances as the pixel count wraps
   always_ff @(posedge clock) begin
      if (reset) begin
         hcount <= '0;
         vcount <= '0;
      end else if (hcount == H_LAST) begin
         hcount <= '0;
         vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end else begin
         hcount <= hcount + 10'd1;
      end
   end

   // decode the current raster position
   always_comb begin
      active = (hcount < H_VIS) && (vcount < V_VIS);
      hsync  = (hcount >= HS_START) && (hcount < HS_END);
      vsync  = (vcount >= VS_START) && (vcount < VS_END);
      first  = (hcount == 10'd0) && (vcount == 10'd0);
   end

endmodule

// File: rtl/vga_overlay_out.sv
// vga_overlay_out: VGA scan-out with fetch requests, latency-matched
// sync/blank and N crosshairs. Optional bars: VGA_OVERLAY_TESTBARS_EN.
module vga_overlay_out
   import vga_pkg::*;
#(
   parameter int H_ACTIVE        = H_ACTIVE_DEF,
   parameter int H_FP            = H_FP_DEF,
   parameter int H_SYNC          = H_SYNC_DEF,
   parameter int H_BP            = H_BP_DEF,
   parameter int V_ACTIVE        = V_ACTIVE_DEF,
   parameter int V_FP            = V_FP_DEF,
   parameter int V_SYNC          = V_SYNC_DEF,
   parameter int V_BP            = V_BP_DEF,
   parameter int PIX_LAT         = 2,
   parameter int N_XH            = 4,
   parameter int XH_THICK        = 1,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset,
`ifdef VGA_OVERLAY_TESTBARS_EN
   input  logic                 test_mode,
`endif
   output logic                 req_valid,
   output logic [9:0]           req_hcount,
   output logic [9:0]           req_vcount,
   input  logic [23:0]          pix_rgb,
   input  logic [N_XH-1:0]      xh_en,
   input  logic [10*N_XH-1:0]   xh_x,
   input  logic [10*N_XH-1:0]   xh_y,
   input  logic [24*N_XH-1:0]   xh_color,
   output logic [7:0]           vga_red,
   output logic [7:0]           vga_green,
   output logic [7:0]           vga_blue,
   output logic                 vga_hsync,
   output logic                 vga_vsync,
   output logic                 vga_blank_b,
   output logic                 frame_start
);

   localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

   logic [9:0]      hcount;
   logic [9:0]      vcount;
   logic            active;
   logic            hs;
   logic            vs;
   logic            first;
   logic            bars;
   logic [N_XH-1:0] hit;
   beat_t           beat_d [PIX_LAT+1];
   logic [N_XH-1:0] hit_d  [PIX_LAT+1];
   beat_t           beat_a;
   logic [N_XH-1:0] hit_a;
   rgb_t            color;

`ifdef VGA_OVERLAY_TESTBARS_EN
   logic [9:0]      hpos_d [PIX_LAT+1];
   logic [12:0]     bar_num;
   assign bars = test_mode;
`else
   assign bars = 1'b0;
`endif

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clock  (clock),
      .reset  (reset),
      .hcount (hcount),
      .vcount (vcount),
      .active (active),
      .hsync  (hs),
      .vsync  (vs),
      .first  (first)
   );

   // fetch request trails the counter by one cycle; position holds in blanking
   always_ff @(posedge clock) begin
      if (reset) begin
         req_valid  <= 1'b0;
         req_hcount <= '0;
         req_vcount <= '0;
      end else begin
         req_valid <= active && !bars;
         if (active) begin
            req_hcount <= hcount;
            req_vcount <= vcount;
         end
      end
   end

   // crosshair hit per channel on the live counters
   always_comb begin
      hit = '0;
      for (int i = 0; i < N_XH; i++) begin
         hit[i] = xh_en[i]
                  && (in_band(hcount, xh_x[10*i +: 10], 11'(XH_THICK))
                  ||  in_band(vcount, xh_y[10*i +: 10], 11'(XH_THICK)));
      end
   end

   // delay control and hits so they meet pix_rgb; reset drops stale beats
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k <= PIX_LAT; k++) begin
            beat_d[k] <= '0;
            hit_d[k]  <= '0;
         end
      end else begin
         beat_d[0] <= '{active, hs, vs, first};
         hit_d[0]  <= hit;
         for (int k = 1; k <= PIX_LAT; k++) begin
            beat_d[k] <= beat_d[k-1];
            hit_d[k]  <= hit_d[k-1];
         end
      end
   end

`ifdef VGA_OVERLAY_TESTBARS_EN
   // carry x alongside the beat so bars follow the output pixel
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k <= PIX_LAT; k++) hpos_d[k] <= '0;
      end else begin
         hpos_d[0] <= hcount;
         for (int k = 1; k <= PIX_LAT; k++) hpos_d[k] <= hpos_d[k-1];
      end
   end
   assign bar_num = {hpos_d[PIX_LAT], 3'b000} / 13'(H_ACTIVE);
`endif

   assign beat_a = beat_d[PIX_LAT];
   assign hit_a  = hit_d[PIX_LAT];

   // blank beats everything, then the lowest hit channel, then the source
   always_comb begin
      color = pix_rgb;
`ifdef VGA_OVERLAY_TESTBARS_EN
      if (bars) color = bar_color(bar_num[2:0]);
`endif
      for (int i = N_XH - 1; i >= 0; i--) begin
         if (hit_a[i]) color = xh_color[24*i +: 24];
      end
      if (!beat_a.active) color = '0;
   end

   // registered pin drive
   always_ff @(posedge clock) begin
      if (reset) begin
         vga_red     <= '0;
         vga_green   <= '0;
         vga_blue    <= '0;
         vga_hsync   <= SYNC_OFF;
         vga_vsync   <= SYNC_OFF;
         vga_blank_b <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         {vga_red, vga_green, vga_blue} <= color;
         vga_hsync   <= beat_a.hsync ^ SYNC_ACTIVE_LOW;
         vga_vsync   <= beat_a.vsync ^ SYNC_ACTIVE_LOW;
         vga_blank_b <= beat_a.active;
         frame_start <= beat_a.first;
      end
   end

endmodule

// File: tb/tb_vga_overlay_out.sv
// tb_vga_overlay_out: directed bench on a reduced 64x48 raster with
// two instances (PIX_LAT 2 with crosshairs, PIX_LAT 5 plain).
module tb_vga_overlay_out;

   localparam int HA = 64;
   localparam int HT = 80;
   localparam int VA = 48;
   localparam int VT = 55;
   localparam int FR = HT * VT;
   localparam int LA = 2;
   localparam int LB = 5;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic tm    = 1'b0;

   always #5 clock = ~clock;

   logic        a_req_valid, b_req_valid;
   logic [9:0]  a_req_h, a_req_v, b_req_h, b_req_v;
   logic [23:0] a_pix, b_pix;
   logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
   logic        a_hs, a_vs, a_bb, a_fs;
   logic        b_hs, b_vs, b_bb, b_fs;

   logic [3:0]  xen = 4'b0111;
   logic [39:0] xx  = {10'd20, 10'd1023, 10'd10, 10'd10};
   logic [39:0] xy  = {10'd20, 10'd47, 10'd8, 10'd5};
   logic [95:0] xc  = {24'hAABBCC, 24'h778899, 24'h445566, 24'h112233};

   int          cx [4] = '{10, 10, 1023, 20};
   int          cy [4] = '{5, 8, 47, 20};
   logic [23:0] cc [4] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
   logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                                24'h00FF00, 24'hFF00FF, 24'hFF0000,
                                24'h0000FF, 24'h000000};

   vga_overlay_out #(
      .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .PIX_LAT(LA), .N_XH(4), .XH_THICK(2), .SYNC_ACTIVE_LOW(1'b1)
   ) dut_a (
      .clock       (clock),
      .reset       (reset),
`ifdef VGA_OVERLAY_TESTBARS_EN
      .test_mode   (tm),
`endif
      .req_valid   (a_req_valid),
      .req_hcount  (a_req_h),
      .req_vcount  (a_req_v),
      .pix_rgb     (a_pix),
      .xh_en       (xen),
      .xh_x        (xx),
      .xh_y        (xy),
      .xh_color    (xc),
      .vga_red     (a_r),
      .vga_green   (a_g),
      .vga_blue    (a_b),
      .vga_hsync   (a_hs),
      .vga_vsync   (a_vs),
      .vga_blank_b (a_bb),
      .frame_start (a_fs)
   );

   vga_overlay_out #(
      .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .PIX_LAT(LB), .N_XH(1), .XH_THICK(1), .SYNC_ACTIVE_LOW(1'b1)
   ) dut_b (
      .clock       (clock),
      .reset       (reset),
`ifdef VGA_OVERLAY_TESTBARS_EN
      .test_mode   (tm),
`endif
      .req_valid   (b_req_valid),
      .req_hcount  (b_req_h),
      .req_vcount  (b_req_v),
      .pix_rgb     (b_pix),
      .xh_en       (1'b0),
      .xh_x        (10'd0),
      .xh_y        (10'd0),
      .xh_color    (24'h0),
      .vga_red     (b_r),
      .vga_green   (b_g),
      .vga_blue    (b_b),
      .vga_hsync   (b_hs),
      .vga_vsync   (b_vs),
      .vga_blank_b (b_bb),
      .frame_start (b_fs)
   );

   // frame-buffer models: fixed-latency return of a position pattern
   logic [23:0] mem_a [LA];
   logic [23:0] mem_b [LB];
   always @(posedge clock) begin
      mem_a[0] <= a_req_valid ? {a_req_v[7:0], a_req_h[7:0], 8'h5A} : 24'h0;
      for (int k = 1; k < LA; k++) mem_a[k] <= mem_a[k-1];
      mem_b[0] <= b_req_valid ? {b_req_v[7:0], b_req_h[7:0], 8'h5A} : 24'h0;
      for (int k = 1; k < LB; k++) mem_b[k] <= mem_b[k-1];
   end
   assign a_pix = mem_a[LA-1];
   assign b_pix = mem_b[LB-1];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int last_fs    = -1;
   int first_fs   = -1;
   int blank_cnt  = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s cyc=%0d observed=%h required=%h",
                tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [23:0] pix_exp(int x, int y, bit ovl);
      logic [23:0] r;
      r = tm ? bar_tab[x/8] : {8'(y), 8'(x), 8'h5A};
      if (ovl) begin
         for (int i = 3; i >= 0; i--) begin
            if (xen[i] && ((x >= cx[i] && x < cx[i] + 2)
                || (y >= cy[i] && y < cy[i] + 2))) r = cc[i];
         end
      end
      return r;
   endfunction

   task automatic model(input int lat, input bit ovl,
                        output logic [23:0] rgb, output logic hs,
                        output logic vs, output logic bb, output logic fs);
      int n, p, x, y;
      n = cyc - lat - 2;
      rgb = '0; hs = 1'b1; vs = 1'b1; bb = 1'b0; fs = 1'b0;
      if (n >= 0) begin
         p  = n % FR;
         x  = p % HT;
         y  = p / HT;
         bb = (x < HA) && (y < VA);
         hs = !(x >= 68 && x < 76);
         vs = !(y >= 50 && y < 52);
         fs = (p == 0);
         if (bb) rgb = pix_exp(x, y, ovl);
      end
   endtask

   task automatic at(input string tag, input int x, input int y,
                     input int tx, input int ty,
                     input logic [23:0] obs, input logic [23:0] exp);
      if (x == tx && y == ty) check(tag, obs, exp);
   endtask

   task automatic check_all();
      logic [23:0] rgb;
      logic hs, vs, bb, fs, rv;
      int n, p, x, y;
      logic [23:0] ao, bo;
      ao = {a_r, a_g, a_b};
      bo = {b_r, b_g, b_b};

      model(LA, 1'b1, rgb, hs, vs, bb, fs);
      check("a_rgb", ao, rgb);
      check("a_hsync", a_hs, hs);
      check("a_vsync", a_vs, vs);
      check("a_blank_b", a_bb, bb);
      check("a_frame_start", a_fs, fs);

      model(LB, 1'b0, rgb, hs, vs, bb, fs);
      check("b_rgb", bo, rgb);
      check("b_hsync", b_hs, hs);
      check("b_blank_b", b_bb, bb);
      check("b_frame_start", b_fs, fs);

      rv = 1'b0; x = 0; y = 0;
      if (cyc >= 1) begin
         p  = (cyc - 1) % FR;
         x  = p % HT;
         y  = p / HT;
         rv = (x < HA) && (y < VA) && !tm;
      end
      check("a_req_valid", a_req_valid, rv);
      check("b_req_valid", b_req_valid, rv);
      if (rv) begin
         check("a_req_pos", {a_req_v, a_req_h}, {10'(y), 10'(x)});
         check("b_req_pos", {b_req_v, b_req_h}, {10'(y), 10'(x)});
      end

      n = cyc - LA - 2;
      if (n >= 0) begin
         p = n % FR; x = p % HT; y = p / HT;
         if (!tm) begin
            at("ch0_over_ch1", x, y, 10, 8, ao, 24'h112233);
            at("ch1_line", x, y, 20, 8, ao, 24'h445566);
            at("no_hit_pix", x, y, 12, 12, ao, 24'h0C0C5A);
            at("last_col", x, y, 63, 0, ao, 24'h003F5A);
            at("origin", x, y, 0, 0, ao, 24'h00005A);
            at("thick_in", x, y, 11, 0, ao, 24'h112233);
            at("thick_out", x, y, 12, 0, ao, 24'h000C5A);
            at("ch0_hline", x, y, 0, 5, ao, 24'h112233);
            at("between", x, y, 0, 7, ao, 24'h07005A);
            at("x1023_line", x, y, 0, 47, ao, 24'h778899);
            at("x1023_end", x, y, 63, 47, ao, 24'h778899);
            at("x1023_nowrap", x, y, 0, 46, ao, 24'h2E005A);
            at("ch0_on_47", x, y, 10, 47, ao, 24'h112233);
            at("ch3_disabled", x, y, 20, 20, ao, 24'h14145A);
         end else begin
            at("bar_white", x, y, 0, 1, ao, 24'hFFFFFF);
            at("bar_yellow", x, y, 8, 1, ao, 24'hFFFF00);
            at("bar_black", x, y, 63, 1, ao, 24'h000000);
            at("xh_over_bar", x, y, 10, 1, ao, 24'h112233);
         end
      end
      n = cyc - LB - 2;
      if (n >= 0 && !tm) begin
         p = n % FR; x = p % HT; y = p / HT;
         at("b_origin", x, y, 0, 0, bo, 24'h00005A);
         at("b_line1", x, y, 0, 1, bo, 24'h01005A);
         at("b_last", x, y, 63, 47, bo, 24'h2F3F5A);
      end

      if (a_fs) begin
         if (last_fs >= 0) begin
            check("fs_period", cyc - last_fs, FR);
            check("blank_count", blank_cnt, HA * VA);
         end
         if (first_fs < 0) first_fs = cyc;
         last_fs   = cyc;
         blank_cnt = 0;
      end
      if (a_bb) blank_cnt++;
   endtask

   task automatic step();
      @(posedge clock);
      if (reset) cyc = 0;
      else cyc++;
      @(negedge clock);
      check_all();
   endtask

   task automatic release_reset();
      reset     = 1'b0;
      last_fs   = -1;
      first_fs  = -1;
      blank_cnt = 0;
   endtask

   initial begin
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      repeat (2) step();

      release_reset();
      repeat (2 * FR + 30 + 20 * HT) step();

      reset = 1'b1;
      repeat (3) step();
      release_reset();
      repeat (FR + 20) step();
      check("fs_after_reset", first_fs, LA + 2);

`ifdef VGA_OVERLAY_TESTBARS_EN
      tm    = 1'b1;
      reset = 1'b1;
      repeat (2) step();
      release_reset();
      repeat (FR + 20) step();
      check("fs_bars", first_fs, LA + 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
